// File: rtl/melody_if.sv
// Control/status bundle between the push-button logic (master) and the melody sequencer (slave).
interface melody_if;
  logic       start;
  logic       stop;
  logic       loop;
  logic       sig_4hz;
  logic       sound;
  logic       busy;
  logic [3:0] note_idx;
  logic       done;

  modport master (
    output start, stop, loop,
    input  sig_4hz, sound, busy, note_idx, done
  );

  modport slave (
    input  start, stop, loop,
    output sig_4hz, sound, busy, note_idx, done
  );
endinterface

// File: rtl/melody_sequencer.sv
// Plays a fixed 16-entry {pitch,dur} note table on a square-wave buzzer output.
// Define MELODY_GAP_EN to insert one silent tick after every note.
module melody_sequencer #(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned TICK_HZ = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  melody_if.slave  bus
);

  localparam int unsigned TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int          TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(TICK_DIV / 2);
  // Widest half-period belongs to the lowest note (C4).
  localparam int          HALF_W   = $clog2(CLK_HZ / (2 * 262) + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PLAY,
`ifdef MELODY_GAP_EN
    S_GAP,
`endif
    S_NEXT,
    S_END
  } state_t;

  // NOTE: the note table is a constant function, so it synthesises to logic and needs no reset.
  function automatic logic [7:0] rom_entry(input logic [3:0] idx);
    case (idx)
      4'd0:    return 8'hA2;
      4'd1:    return 8'h01;
      4'd2:    return 8'h11;
      default: return 8'hF0;
    endcase
  endfunction

  function automatic logic [HALF_W-1:0] half_of(input logic [3:0] p);
    case (p)
      4'd1:    return HALF_W'(CLK_HZ / (2 * 262));
      4'd2:    return HALF_W'(CLK_HZ / (2 * 277));
      4'd3:    return HALF_W'(CLK_HZ / (2 * 294));
      4'd4:    return HALF_W'(CLK_HZ / (2 * 311));
      4'd5:    return HALF_W'(CLK_HZ / (2 * 330));
      4'd6:    return HALF_W'(CLK_HZ / (2 * 349));
      4'd7:    return HALF_W'(CLK_HZ / (2 * 370));
      4'd8:    return HALF_W'(CLK_HZ / (2 * 392));
      4'd9:    return HALF_W'(CLK_HZ / (2 * 415));
      4'd10:   return HALF_W'(CLK_HZ / (2 * 440));
      4'd11:   return HALF_W'(CLK_HZ / (2 * 466));
      4'd12:   return HALF_W'(CLK_HZ / (2 * 494));
      default: return HALF_W'(1);
    endcase
  endfunction

  state_t            state;
  logic [3:0]        idx;
  logic [3:0]        pitch;
  logic [4:0]        ticks_left;
  logic [TICK_W-1:0] phase;
  logic [TICK_W-1:0] presc;
  logic [TICK_W-1:0] presc_next;
  logic [HALF_W-1:0] tone_cnt;
  logic [HALF_W-1:0] half_last;
  logic              sound;
  logic              busy;
  logic              sig_4hz;
  logic [7:0]        rom_q;
  logic              is_tone;
  logic              launch;

  assign rom_q   = rom_entry(idx);
  assign is_tone = (pitch != 4'd0) && (pitch <= 4'd12);
  assign launch  = (state == S_IDLE) && bus.start && !bus.stop;

  // Free-running 4 Hz prescaler, re-aligned when playback is launched.
  always_comb begin
    presc_next = (presc == TICK_LAST) ? '0 : presc + 1'b1;
    if (launch) presc_next = '0;
  end

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc   <= '0;
      sig_4hz <= 1'b0;
    end else begin
      presc   <= presc_next;
      sig_4hz <= (presc_next < TICK_HALF);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      idx        <= '0;
      pitch      <= '0;
      ticks_left <= '0;
      phase      <= '0;
      tone_cnt   <= '0;
      half_last  <= '0;
      sound      <= 1'b0;
      busy       <= 1'b0;
    end else if (bus.stop) begin
      state <= S_IDLE;
      idx   <= '0;
      sound <= 1'b0;
      busy  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          idx   <= '0;
          sound <= 1'b0;
          if (bus.start) begin
            state <= S_LOAD;
            busy  <= 1'b1;
          end
        end

        S_LOAD: begin
          if (rom_q[7:4] == 4'd15) begin
            state <= S_END;
          end else begin
            pitch      <= rom_q[7:4];
            ticks_left <= (rom_q[3:0] == 4'd0) ? 5'd16 : {1'b0, rom_q[3:0]};
            phase      <= '0;
            tone_cnt   <= '0;
            half_last  <= half_of(rom_q[7:4]) - 1'b1;
            sound      <= 1'b0;
            state      <= S_PLAY;
          end
        end

        S_PLAY: begin
          if (is_tone) begin
            if (tone_cnt == half_last) begin
              tone_cnt <= '0;
              sound    <= ~sound;
            end else begin
              tone_cnt <= tone_cnt + 1'b1;
            end
          end
          // Duration is counted in whole ticks from the note's own start, so every note is exact.
          if (phase == TICK_LAST) begin
            phase      <= '0;
            ticks_left <= ticks_left - 1'b1;
            if (ticks_left == 5'd1) begin
              sound <= 1'b0;
`ifdef MELODY_GAP_EN
              state <= S_GAP;
`else
              state <= S_NEXT;
`endif
            end
          end else begin
            phase <= phase + 1'b1;
          end
        end

`ifdef MELODY_GAP_EN
        S_GAP: begin
          if (phase == TICK_LAST) begin
            phase <= '0;
            state <= S_NEXT;
          end else begin
            phase <= phase + 1'b1;
          end
        end
`endif

        S_NEXT: begin
          if (idx == 4'd15) begin
            state <= S_END;
          end else begin
            idx   <= idx + 1'b1;
            state <= S_LOAD;
          end
        end

        S_END: begin
          if (bus.loop) begin
            idx   <= '0;
            state <= S_LOAD;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sound    = sound;
  assign bus.busy     = busy;
  assign bus.note_idx = idx;
  assign bus.sig_4hz  = sig_4hz;
  // Done must coincide with the END cycle itself, so it is decoded from state and the live loop/stop inputs.
  assign bus.done     = (state == S_END) && !bus.loop && !bus.stop;

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer at CLK_HZ = 4000 (TICK_DIV = 1000); honours MELODY_GAP_EN.
module tb_melody_sequencer;

`ifdef MELODY_GAP_EN
  localparam int GAP = 1000;
`else
  localparam int GAP = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  int   done_cnt = 0;

  melody_if bus ();

  melody_sequencer #(.CLK_HZ(4000), .TICK_HZ(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t required below 3000000", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
  endtask

  task automatic measure(input int cycles, output int highs, output int rises);
    logic prev;
    prev  = bus.sound;
    highs = 0;
    rises = 0;
    for (int i = 0; i < cycles; i++) begin
      tick(1);
      if (bus.sound === 1'b1) highs++;
      if (bus.sound === 1'b1 && prev === 1'b0) rises++;
      prev = bus.sound;
    end
  endtask

  task automatic run_len(input logic v, output int n);
    n = 0;
    while (bus.sig_4hz === v && n < 3000) begin
      tick(1);
      n++;
    end
  endtask

  initial begin
    int   highs, rises, len;
    logic cur;

    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.loop  = 1'b0;

    // Reset state
    #2;
    check("rst_busy", bus.busy, 0);
    check("rst_sound", bus.sound, 0);
    check("rst_idx", bus.note_idx, 0);
    check("rst_done", bus.done, 0);
    check("rst_sig", bus.sig_4hz, 0);
    tick(3);
    rst_n = 1'b1;
    tick(2);

    // Tick indicator while idle: 500 high, 500 low
    cur = bus.sig_4hz;
    run_len(cur, len);
    run_len(~cur, len);
    check("sig_first_run", len, 500);
    run_len(cur, len);
    check("sig_second_run", len, 500);

    // Start and stop together in IDLE
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    tick(1);
    check("startstop_busy", bus.busy, 0);
    tick(3);
    check("startstop_busy_later", bus.busy, 0);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    tick(2);

    // Full melody, no loop
    pulse_start();
    check("load_busy", bus.busy, 1);
    check("load_idx", bus.note_idx, 0);
    measure(2000, highs, rises);
    check("a4_highs", highs, 1000);
    check("a4_rises", rises, 250);
`ifdef MELODY_GAP_EN
    measure(GAP, highs, rises);
    check("gap1_highs", highs, 0);
`endif
    tick(1);
    check("next1_sound", bus.sound, 0);
    check("next1_idx", bus.note_idx, 0);
    tick(1);
    check("load1_idx", bus.note_idx, 1);
    measure(1000, highs, rises);
    check("rest_highs", highs, 0);
`ifdef MELODY_GAP_EN
    measure(GAP, highs, rises);
    check("gap2_highs", highs, 0);
`endif
    tick(2);
    check("load2_idx", bus.note_idx, 2);
    measure(1000, highs, rises);
    check("c4_highs", highs, 497);
    check("c4_rises", rises, 71);
`ifdef MELODY_GAP_EN
    measure(GAP, highs, rises);
    check("gap3_highs", highs, 0);
`endif
    tick(2);
    check("load3_idx", bus.note_idx, 3);
    check("pre_end_done", bus.done, 0);
    tick(1);
    check("end_done", bus.done, 1);
    check("end_busy", bus.busy, 1);
    tick(1);
    check("idle_done", bus.done, 0);
    check("idle_busy", bus.busy, 0);
    check("done_count_1", done_cnt, 1);
    tick(3);

    // Asynchronous reset in the middle of A4
    pulse_start();
    tick(5);
    check("mid_a4_sound", bus.sound, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_sound", bus.sound, 0);
    check("arst_busy", bus.busy, 0);
    check("arst_sig", bus.sig_4hz, 0);
    tick(3);
    rst_n = 1'b1;
    tick(5);
    check("post_rst_busy", bus.busy, 0);
    check("post_rst_idx", bus.note_idx, 0);

    // Stop 500 cycles into A4
    pulse_start();
    tick(501);
    check("pre_stop_busy", bus.busy, 1);
    bus.stop = 1'b1;
    tick(1);
    bus.stop = 1'b0;
    check("stop_sound", bus.sound, 0);
    check("stop_busy", bus.busy, 0);
    check("stop_idx", bus.note_idx, 0);
    tick(3);
    check("stop_stays_idle", bus.busy, 0);

    // Looping playback
    bus.loop = 1'b1;
    pulse_start();
    tick(4006 + 3 * GAP);
    check("loop_load3_idx", bus.note_idx, 3);
    tick(1);
    check("loop_end_done", bus.done, 0);
    check("loop_end_busy", bus.busy, 1);
    tick(1);
    check("loop_restart_idx", bus.note_idx, 0);
    check("loop_restart_busy", bus.busy, 1);
    measure(8, highs, rises);
    check("loop_a4_highs", highs, 4);
    bus.stop = 1'b1;
    tick(1);
    bus.stop = 1'b0;
    bus.loop = 1'b0;
    check("loop_stop_busy", bus.busy, 0);
    check("done_count_final", done_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/melody_sequencer.md
# melody_sequencer

Plays a fixed 16-entry note table on the buzzer output. Each entry selects a tone (or rest) and a duration counted in 4 Hz ticks. It owns the 4 Hz tick prescaler and the tone half-period divider, and sequences them from start to end marker, with optional looping. It sits between the board push-button/control logic and the piezo pin, and replaces free-running tone generation with scheduled playback.

## Interface
- CLK_HZ, 50_000_000: input clock frequency; all dividers are derived from it at elaboration.
- TICK_HZ, 4: note-duration tick rate. TICK_DIV = CLK_HZ/TICK_HZ.
- iCLK  in  1  system clock, rising edge.
- iRST_N  in  1  reset, asynchronous and active-low.
- iSTART  in  1  level; starts playback from entry 0 when sampled high in IDLE.
- iSTOP  in  1  level; aborts playback when sampled high in any state.
- iLOOP  in  1  sampled at end of table; 1 = restart at entry 0.
- oSIG_4Hz  out  1  tick indicator; high during the first TICK_DIV/2 cycles of each tick period.
- oSOUND  out  1  square-wave tone to buzzer.
- oBUSY  out  1  high in every state except IDLE.
- oNOTE_IDX  out  4  index of the entry being played.
- oDONE  out  1  one-cycle pulse on normal end of melody.

## Operation
- ROM: 16 × 8 bits, {pitch[7:4], dur[3:0]}. Default contents:
  - entry 0 = {10,2}
  - entry 1 = {0,1}
  - entry 2 = {1,1}
  - entries 3..15 = {15,0}
- Pitch codes:
  - 0, 13, 14: rest; oSOUND held 0.
  - 1..12: C4..B4 at 262, 277, 294, 311, 330, 349, 370, 392, 415, 440, 466, 494 Hz.
  - 15: end marker.
- Tone divider: HALF[p] = CLK_HZ/(2·f), truncated. oSOUND toggles every HALF cycles.
- Duration: dur = 0 means 16 ticks. A note lasts exactly dur·TICK_DIV cycles.
- Tick prescaler counts 0..TICK_DIV-1. It free-runs in IDLE and clears on the IDLE→LOAD transition, so note boundaries align with ticks.
- States:
  - IDLE: oSOUND = 0, index = 0. iSTART && !iSTOP → LOAD.
  - LOAD: one cycle. Read ROM[index].
    - Pitch 15 → END.
    - Otherwise latch pitch and dur, clear tone counter, set oSOUND = 0 → PLAY.
  - PLAY: tone runs. Decrement the tick count on each tick wrap. When it reaches 0, go to GAP (if enabled) or NEXT.
  - GAP: one tick of silence → NEXT.
  - NEXT: one cycle.
    - Index 15 → END.
    - Otherwise index+1 → LOAD.
  - END: one cycle.
    - iLOOP = 1: index = 0 → LOAD; no oDONE.
    - iLOOP = 0: oDONE = 1 → IDLE.
- iSTOP sampled high in any state forces IDLE on the next edge: oSOUND = 0, index = 0, no oDONE. iSTOP beats a simultaneous iSTART.
- A held iSTART retriggers playback after oDONE, one cycle after returning to IDLE.

## Timing
- Reset (iRST_N low, asynchronous): state IDLE; all counters 0; oSIG_4Hz, oSOUND, oBUSY, oNOTE_IDX, oDONE all 0.
- Release of reset is synchronous to iCLK.
- iSTART high at edge n:
  - oBUSY = 1 after edge n (LOAD).
  - First tone cycle after edge n+1.
- Each note occupies dur·TICK_DIV cycles in PLAY. LOAD and NEXT each add 1 cycle per entry.
- NEXT and LOAD do not stall the prescaler. Each note after the first is therefore offset by 2 cycles per entry from tick alignment; this drift is accepted.
- oNOTE_IDX updates on the NEXT→LOAD edge.
- oDONE is high for exactly the cycle state == END with iLOOP = 0.

## Configuration
- MELODY_GAP_EN:
  - Defined: GAP state compiled in; one silent tick (TICK_DIV cycles, oSOUND = 0) after every note, including rests.
  - Undefined: PLAY→NEXT directly; notes are back-to-back.

## Test plan
- Reset mid-PLAY, using CLK_HZ = 4000 (TICK_DIV = 1000): assert iRST_N = 0 → all outputs 0 immediately, without waiting for an edge. After release, oBUSY stays 0 until iSTART.
- Default ROM, CLK_HZ = 4000, no gap, iSTART pulse, iLOOP = 0:
  - A4 (HALF = 4): oSOUND period 8 cycles for 2000 cycles.
  - Rest for 1000 cycles.
  - C4 (HALF = 7): period 14 for 1000 cycles.
  - oDONE pulse, then oBUSY = 0. Total 4000 + 2·3 + 1 cycles after start.
- Same stimulus with MELODY_GAP_EN: 1000-cycle silence after each of the 3 notes; oDONE arrives 3000 cycles later than without the gap.
- iLOOP = 1: after entry 3 is read, oNOTE_IDX returns to 0 and A4 restarts; no oDONE is ever seen.
- iSTOP pulsed 500 cycles into A4 → next cycle oSOUND = 0, oBUSY = 0, oNOTE_IDX = 0, no oDONE.
- iSTART and iSTOP high on the same edge in IDLE → remains IDLE.
- oSIG_4Hz in IDLE: high 500 cycles, low 500 cycles, repeating.
